nrd24: RTL and testbench
========================

# nrd24

24-bit unsigned integer divider built on the non-restoring algorithm, fully pipelined with one quotient bit resolved per stage. It accepts a new dividend/divisor pair every clock and returns quotient and remainder a fixed 24 cycles later. It is the pipelined arithmetic leaf used wherever a datapath needs sustained-throughput 24-bit division.

## Interface
- No parameters; all widths are fixed at 24 bits.
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all pipeline state.
- in_valid  input  1  marks a and b as a valid operation this cycle.
- a  input  24  dividend, unsigned.
- b  input  24  divisor, unsigned.
- quo  output  24  quotient floor(a/b), registered.
- rem  output  24  remainder a - b*quo, registered.
- out_valid  output  1  quo/rem hold a valid result this cycle.

## Operation
- Algorithm, per operation:
  - Partial remainder R is 26-bit signed, initialised to 0.
  - For i = 23 down to 0:
    - If R ≥ 0, R = 2R + a[i] − b.
    - Otherwise, R = 2R + a[i] + b.
    - q[i] = 1 when the new R ≥ 0, else 0.
  - Final correction: if R < 0, R = R + b.
  - quo = q and rem = R[23:0].
- Pipeline:
  - 24 stages; stage k (k = 1..24) performs iteration i = 24 − k.
  - Each stage register carries:
    - partial remainder (26 b)
    - remaining dividend bits
    - divisor (24 b)
    - quotient bits accumulated so far
    - valid bit
  - Stage 1 computes from a/b combinationally and registers on the edge.
  - The final correction is combinational after stage 23's register and is registered into stage 24, which drives quo/rem directly.
- Divisor zero: no special-case logic. With b = 0 the algorithm yields quo = 24'hFFFFFF and rem = a. This result is required and must be preserved.
- Result for every b ≠ 0 must satisfy a = b·quo + rem and rem < b.
- in_valid does not gate the datapath. Data advances every cycle regardless; in_valid only travels alongside the data as out_valid.
- quo/rem for cycles with out_valid = 0 are don't-care. Implementations simply propagate whatever was sampled.
- No stall/backpressure input exists; the downstream consumer must accept one result per cycle.

## Timing
- Throughput: one operation per clock, back-to-back, no bubbles required.
- Latency: operands sampled at rising edge t appear on quo/rem/out_valid after rising edge t+23. That is 24 register ranks, including the sampling edge.
- Reset (rst_n low, asynchronous assert):
  - All stage registers clear immediately, without waiting for a clock edge.
  - quo = 0, rem = 0, out_valid = 0.
- Reset release: the first valid result emerges 24 edges after the first in_valid = 1 sample.
- Reset mid-operation: all in-flight operations are discarded, and out_valid stays 0 until new operations drain through.
- No combinational path from inputs to outputs.

## Test plan
- Basic vectors, one per cycle back-to-back with in_valid = 1. After 24 cycles each result must appear in order, with out_valid high:
  - 50/4 → quo 12, rem 2
  - 40/3 → 13, 1
  - 40/2 → 20, 0
  - 24'h8001FF/2 → 4194559, 1
  - 24'hAA4000/24'h0A0000 → 17, 16384
  - 24'hF20000/24'h500000 → 3, 131072
- Edge operands:
  - 24'hFFFFFF/1 → quo 24'hFFFFFF, rem 0
  - 5/9 → quo 0, rem 5
  - 24'hFFFFFF/24'hFFFFFF → quo 1, rem 0
- Divide by zero: 1234/0 → quo 24'hFFFFFF, rem 1234.
- Latency/valid:
  - A single in_valid pulse yields exactly one out_valid pulse exactly 24 cycles later.
  - Gaps in in_valid reproduce as identical gaps in out_valid.
- Async reset:
  - Assert rst_n low between clock edges while the pipeline is full; outputs go to 0 and out_valid to 0 immediately.
  - After release, no stale result ever raises out_valid.
- Random regression: ≥10k random (a, b ≠ 0) pairs streamed continuously. A scoreboard checks quo == a/b and rem == a%b at 24-cycle delay.

Source files
------------

// File: rtl/nrd24_if.sv
// Operand/result bundle for the nrd24 pipelined divider.
// The master side supplies operands; the slave side (the divider) returns results.
interface nrd24_if;
   logic        in_valid;
   logic [23:0] a;
   logic [23:0] b;
   logic [23:0] quo;
   logic [23:0] rem;
   logic        out_valid;

   modport master (
      output in_valid, a, b,
      input  quo, rem, out_valid
   );

   modport slave (
      input  in_valid, a, b,
      output quo, rem, out_valid
   );
endinterface

// File: rtl/nrd24.sv
// nrd24: 24-bit unsigned non-restoring divider, one quotient bit per stage.
// 24 register ranks; operands sampled on edge t appear on quo/rem after edge t+23.
// A divisor of zero falls out of the algorithm as quo = 24'hFFFFFF, rem = a.
module nrd24 (
   input  logic      clk,
   input  logic      rst_n,
   nrd24_if.slave    bus
);

   // Stage k holds the state after iteration i = 24 - k.
   // aq packs the not-yet-consumed dividend bits in the upper part and the
   // quotient bits resolved so far in the lower part; the MSB is always the
   // next dividend bit, and after the last stage the word is the quotient.
   logic signed [25:0] r_q  [1:23];
   logic signed [25:0] r_d  [1:23];
   logic [23:0]        aq_q [1:24];
   logic [23:0]        aq_d [1:24];
   logic [23:0]        b_q  [1:23];
   logic [23:0]        b_d  [1:23];
   logic               v_q  [1:24];
   logic               v_d  [1:24];
   logic [23:0]        rem_q;
   logic [23:0]        rem_d;

   logic signed [25:0] r24_n;
   logic               unused_r24;

   // One non-restoring iteration: shift in the next dividend bit, then
   // subtract the divisor if the partial remainder is non-negative, else add.
   function automatic logic signed [25:0] nr_step(
      input logic signed [25:0] r,
      input logic               abit,
      input logic [23:0]        d
   );
      logic signed [25:0] sh;
      logic signed [25:0] dd;
      sh = {r[24:0], abit};
      dd = {2'b00, d};
      return r[25] ? (sh + dd) : (sh - dd);
   endfunction

   // Next-state for every pipeline rank; the final rank also applies the
   // remainder correction (the corrected value always lies in [0, b), so
   // 24-bit modular arithmetic is exact there).
   always_comb begin
      r_d   = r_q;
      aq_d  = aq_q;
      b_d   = b_q;
      v_d   = v_q;
      rem_d = rem_q;

      r_d[1]  = nr_step(26'sd0, bus.a[23], bus.b);
      aq_d[1] = {bus.a[22:0], ~r_d[1][25]};
      b_d[1]  = bus.b;
      v_d[1]  = bus.in_valid;

      for (int k = 2; k <= 23; k++) begin
         r_d[k]  = nr_step(r_q[k-1], aq_q[k-1][23], b_q[k-1]);
         aq_d[k] = {aq_q[k-1][22:0], ~r_d[k][25]};
         b_d[k]  = b_q[k-1];
         v_d[k]  = v_q[k-1];
      end

      r24_n    = nr_step(r_q[23], aq_q[23][23], b_q[23]);
      aq_d[24] = {aq_q[23][22:0], ~r24_n[25]};
      v_d[24]  = v_q[23];
      rem_d    = r24_n[25] ? (r24_n[23:0] + b_q[23]) : r24_n[23:0];
   end

   // Bit 24 of the last partial remainder is not needed once the sign is known.
   assign unused_r24 = r24_n[24];

   // Pipeline registers; data advances every cycle, valid just rides along.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= 23; k++) begin
            r_q[k] <= '0;
            b_q[k] <= '0;
         end
         for (int k = 1; k <= 24; k++) begin
            aq_q[k] <= '0;
            v_q[k]  <= 1'b0;
         end
         rem_q <= '0;
      end else begin
         r_q   <= r_d;
         aq_q  <= aq_d;
         b_q   <= b_d;
         v_q   <= v_d;
         rem_q <= rem_d;
      end
   end

   assign bus.quo       = aq_q[24];
   assign bus.rem       = rem_q;
   assign bus.out_valid = v_q[24];

endmodule

// File: tb/tb_nrd24.sv
// Bench for nrd24: directed vectors, valid-gap patterns, async reset and a
// long random stream, all checked against a plain a/b, a%b reference.
module tb_nrd24;

   typedef struct {
      logic        v;
      logic [23:0] a;
      logic [23:0] b;
      logic [23:0] eq;
      logic [23:0] er;
   } op_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   op_t  hist[$];

   nrd24_if bus ();

   nrd24 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one operand slot, clock it in, then check what emerges this cycle.
   task automatic apply(input op_t op);
      op_t e;
      logic ev;
      bus.in_valid = op.v;
      bus.a        = op.a;
      bus.b        = op.b;
      @(posedge clk);
      #1;
      hist.push_back(op);
      if (hist.size() > 24) void'(hist.pop_front());
      ev = 1'b0;
      e  = hist[0];
      if (hist.size() == 24) ev = e.v;
      chk("out_valid", {23'b0, bus.out_valid}, {23'b0, ev});
      if (ev) begin
         chk($sformatf("quo %0h/%0h", e.a, e.b), bus.quo, e.eq);
         chk($sformatf("rem %0h/%0h", e.a, e.b), bus.rem, e.er);
      end
   endtask

   // Reference: ordinary integer division, divide-by-zero defined as all-ones / a.
   task automatic cyc(input logic v, input logic [23:0] ai, input logic [23:0] bi);
      op_t op;
      op.v  = v;
      op.a  = ai;
      op.b  = bi;
      op.eq = (bi == 24'd0) ? 24'hFFFFFF : ai / bi;
      op.er = (bi == 24'd0) ? ai : ai % bi;
      apply(op);
   endtask

   // Directed vector with the expected result written out explicitly.
   task automatic cyc_k(input logic [23:0] ai, input logic [23:0] bi,
                        input logic [23:0] eq, input logic [23:0] er);
      op_t op;
      op.v  = 1'b1;
      op.a  = ai;
      op.b  = bi;
      op.eq = eq;
      op.er = er;
      apply(op);
   endtask

   function automatic logic [23:0] rnd_a();
      case ($urandom_range(0, 3))
         0:       return 24'($urandom_range(0, 255));
         1:       return 24'hFFFFFF - 24'($urandom_range(0, 255));
         default: return 24'($urandom);
      endcase
   endfunction

   function automatic logic [23:0] rnd_b_nz();
      case ($urandom_range(0, 3))
         0:       return 24'($urandom_range(1, 15));
         1:       return 24'($urandom_range(1, 4095));
         2:       return 24'($urandom_range(24'h800000, 24'hFFFFFF));
         default: return 24'($urandom_range(1, 24'hFFFFFF));
      endcase
   endfunction

   initial begin
      n_vec        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;

      // Reset state.
      @(posedge clk);
      #1;
      chk("reset quo", bus.quo, 24'd0);
      chk("reset rem", bus.rem, 24'd0);
      chk("reset out_valid", {23'b0, bus.out_valid}, 24'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      hist.delete();

      // Basic and edge vectors, back to back.
      cyc_k(24'd50, 24'd4, 24'd12, 24'd2);
      cyc_k(24'd40, 24'd3, 24'd13, 24'd1);
      cyc_k(24'd40, 24'd2, 24'd20, 24'd0);
      cyc_k(24'h8001FF, 24'd2, 24'd4194559, 24'd1);
      cyc_k(24'hAA4000, 24'h0A0000, 24'd17, 24'd16384);
      cyc_k(24'hF20000, 24'h500000, 24'd3, 24'd131072);
      cyc_k(24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0);
      cyc_k(24'd5, 24'd9, 24'd0, 24'd5);
      cyc_k(24'hFFFFFF, 24'hFFFFFF, 24'd1, 24'd0);
      cyc_k(24'd1234, 24'd0, 24'hFFFFFF, 24'd1234);
      cyc_k(24'd0, 24'd7, 24'd0, 24'd0);
      cyc_k(24'd0, 24'd0, 24'hFFFFFF, 24'd0);

      // Single pulse followed by gap patterns.
      for (int i = 0; i < 30; i++) cyc(1'b0, rnd_a(), rnd_b_nz());
      cyc(1'b1, 24'd1000, 24'd7);
      for (int i = 0; i < 30; i++) cyc(1'b0, rnd_a(), rnd_b_nz());
      for (int i = 0; i < 40; i++) cyc((i % 3) != 1 && (i % 7) != 0, rnd_a(), rnd_b_nz());
      for (int i = 0; i < 24; i++) cyc(1'b0, rnd_a(), rnd_b_nz());

      // Async reset in the middle of a full pipeline.
      for (int i = 0; i < 30; i++) cyc(1'b1, rnd_a(), rnd_b_nz());
      #3;
      rst_n = 1'b0;
      #1;
      chk("async rst quo", bus.quo, 24'd0);
      chk("async rst rem", bus.rem, 24'd0);
      chk("async rst out_valid", {23'b0, bus.out_valid}, 24'd0);
      @(posedge clk);
      #1;
      chk("held rst out_valid", {23'b0, bus.out_valid}, 24'd0);
      #2;
      rst_n = 1'b1;
      hist.delete();
      for (int i = 0; i < 30; i++) cyc(1'b0, rnd_a(), rnd_b_nz());
      for (int i = 0; i < 5; i++) cyc(1'b1, rnd_a(), rnd_b_nz());
      for (int i = 0; i < 30; i++) cyc(1'b0, rnd_a(), rnd_b_nz());

      // Continuous random regression, b nonzero.
      for (int i = 0; i < 10000; i++) cyc(1'b1, rnd_a(), rnd_b_nz());

      // Random valid pattern with occasional zero divisor.
      for (int i = 0; i < 300; i++)
         cyc(1'($urandom_range(0, 1)), rnd_a(),
             ($urandom_range(0, 15) == 0) ? 24'd0 : rnd_b_nz());

      for (int i = 0; i < 26; i++) cyc(1'b0, 24'd0, 24'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
